// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, instruction field positions,
// the HALT opcode and the fetch-stage state encoding.
// Instruction layout: {op[3:0], ra[1:0], rb[1:0], imm[7:0]}.
package cpu_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned INS_W  = 16;

    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RA_MSB  = 11;
    localparam int unsigned RA_LSB  = 10;
    localparam int unsigned RB_MSB  = 9;
    localparam int unsigned RB_LSB  = 8;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    function automatic logic is_halt(input logic [INS_W-1:0] ins);
        return ins[OP_MSB:OP_LSB] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO holding fetched {pc, ins} words.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   push         write push_data this cycle
//   push_data    entry to write
//   pop          consume the head entry this cycle
//   flush        discard all entries (overrides push/pop)
//   count        number of valid entries (0..2)
//   head_data    oldest entry; reads 0 after reset
// Entries are kept in a head/tail shift pair so the head is always a
// register and needs no read mux.
module fetch_buffer #(
    parameter int unsigned DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head_data
);

    logic [DATA_W-1:0] tail_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            head_data <= '0;
            tail_data <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head_data <= push_data;
                    else               tail_data <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_data <= tail_data;
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_data <= push_data;
                    end else begin
                        head_data <= tail_data;
                        tail_data <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage feeding the IF/ID register.
// Owns the PC, issues one read per cycle to a synchronous-read instruction
// memory and buffers returned instructions with their PC for decode.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   imem_req, imem_addr        memory read strobe and address
//   imem_rdata                 read data, valid one cycle after the request
//   redirect_valid, redirect_pc  load new PC, flush fetched/in-flight work
//   out_valid, out_ready       handshake towards decode
//   out_ins, out_pc            head instruction and its PC
//   halted                     fetch stopped on a HALT opcode
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INS_W-1:0]  imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INS_W-1:0]  out_ins,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
);

    localparam int unsigned ENTRY_W = ADDR_W + INS_W;

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              buf_push;
    logic              buf_pop;
    logic [1:0]        buf_count;
    logic [ENTRY_W-1:0] buf_head;
    logic [2:0]        outstanding;

    // A response is kept only if nothing redirected or halted fetch since it
    // was issued; redirect blocks issue, so checking the return cycle suffices.
    assign buf_push = inflight && !redirect_valid && (state == RUN) && !rst;

    assign out_valid = (buf_count != 2'd0) && !redirect_valid;
    assign buf_pop   = out_valid && out_ready;

    // Credit: buffered + in-flight, less this cycle's pop, must leave a slot.
    assign outstanding = {1'b0, buf_count} + {2'b00, inflight};
    assign imem_req    = (state == RUN) && !rst && !redirect_valid &&
                         (outstanding < (3'd2 + {2'b00, buf_pop}));
    assign imem_addr   = pc;

    assign halted  = (state == HALTED);
    assign out_ins = buf_head[INS_W-1:0];
    assign out_pc  = buf_head[ENTRY_W-1:INS_W];

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = RUN;
        end else if (buf_push && is_halt(imem_rdata)) begin
            state_nxt = HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= imem_req;
            if (imem_req) inflight_pc <= pc;
            if (redirect_valid) pc <= redirect_pc;
            else if (imem_req)  pc <= pc + 1'b1;
        end
    end

    fetch_buffer #(
        .DATA_W(ENTRY_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data ({inflight_pc, imem_rdata}),
        .pop       (buf_pop),
        .flush     (redirect_valid),
        .count     (buf_count),
        .head_data (buf_head)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a synchronous-read memory model
// whose default contents are 16'h1200 | address.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ins;
    logic [7:0]  out_pc;
    logic        halted;

    logic [15:0] mem [256];

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    instr_fetch_unit #(
        .RESET_PC(8'h00)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ins        (out_ins),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem[imem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Buffer must never be written while full without a simultaneous pop.
    always @(negedge clk) begin
        if (rst === 1'b0)
            check("no_overflow",
                  {31'd0, dut.buf_push && !dut.buf_pop && (dut.buf_count == 2'd2)}, 32'd0);
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    // Leaves the bench at the start of the first cycle with rst=0 (c0).
    task automatic do_reset;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1200 | 16'(i);
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b1;

        // Reset values
        next_cycle();
        sample();
        check("rst_req",    imem_req,  0);
        check("rst_valid",  out_valid, 0);
        check("rst_halted", halted,    0);
        check("rst_ins",    out_ins,   0);
        check("rst_pc",     out_pc,    0);
        next_cycle();
        rst = 1'b0;

        // Streaming with out_ready high
        for (int k = 0; k < 8; k++) begin
            sample();
            check("t1_req",  imem_req,  1);
            check("t1_addr", imem_addr, k);
            if (k >= 2) begin
                check("t1_valid", out_valid, 1);
                check("t1_pc",    out_pc,    k - 2);
                check("t1_ins",   out_ins,   32'h1200 + k - 2);
            end else begin
                check("t1_valid0", out_valid, 0);
            end
            next_cycle();
        end

        // Backpressure: out_ready low for 5 cycles
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sample();
            check("t2_req", imem_req, (k < 2) ? 1 : 0);
            if (k < 2) check("t2_addr", imem_addr, k);
            if (k >= 2) begin
                check("t2_hold_valid", out_valid, 1);
                check("t2_hold_pc",    out_pc,    0);
            end
            next_cycle();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample();
            check("t2_valid", out_valid, 1);
            check("t2_pc",    out_pc,    k);
            check("t2_ins",   out_ins,   32'h1200 + k);
            if (k == 0) begin
                check("t2_resume_req",  imem_req,  1);
                check("t2_resume_addr", imem_addr, 2);
            end
            next_cycle();
        end

        // Redirect with one entry buffered and one in flight
        do_reset();
        out_ready = 1'b0;
        next_cycle();               // c0
        next_cycle();               // c1
        redirect_valid = 1'b1;      // c2
        redirect_pc = 8'h40;
        sample();
        check("t3_redir_valid", out_valid, 0);
        check("t3_redir_req",   imem_req,  0);
        next_cycle();
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        sample();                   // c3
        check("t3_req",    imem_req,  1);
        check("t3_addr",   imem_addr, 8'h40);
        check("t3_flushed", out_valid, 0);
        next_cycle();
        sample();                   // c4
        check("t3_addr2",   imem_addr, 8'h41);
        check("t3_nostale", out_valid, 0);
        next_cycle();
        sample();                   // c5
        check("t3_valid", out_valid, 1);
        check("t3_pc",    out_pc,    8'h40);
        check("t3_ins",   out_ins,   16'h1240);
        next_cycle();
        sample();
        check("t3_pc2", out_pc, 8'h41);
        next_cycle();

        // HALT at word 3
        mem[3] = 16'hF000;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            sample();
            check("t4_req",  imem_req,  1);
            check("t4_addr", imem_addr, k);
            if (k >= 2) check("t4_pc", out_pc, k - 2);
            check("t4_run", halted, 0);
            next_cycle();
        end
        sample();                   // c5
        check("t4_halt_valid", out_valid, 1);
        check("t4_halt_pc",    out_pc,    3);
        check("t4_halt_ins",   out_ins,   16'hF000);
        check("t4_halted",     halted,    1);
        check("t4_halt_req",   imem_req,  0);
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            sample();
            check("t4_drop04", out_valid, 0);
            check("t4_noreq",  imem_req,  0);
            check("t4_stay",   halted,    1);
            next_cycle();
        end
        redirect_valid = 1'b1;
        redirect_pc = 8'h10;
        sample();
        check("t4_redir_halted", halted,   1);
        check("t4_redir_req",    imem_req, 0);
        next_cycle();
        redirect_valid = 1'b0;
        sample();
        check("t4_resumed", halted,    0);
        check("t4_req10",   imem_req,  1);
        check("t4_addr10",  imem_addr, 8'h10);
        next_cycle();
        next_cycle();
        sample();
        check("t4_valid10", out_valid, 1);
        check("t4_pc10",    out_pc,    8'h10);
        check("t4_ins10",   out_ins,   16'h1210);
        next_cycle();
        mem[3] = 16'h1203;

        // PC wrap after redirect to FE
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 8'hFE;
        next_cycle();
        redirect_valid = 1'b0;
        sample();
        check("t5_addr", imem_addr, 8'hFE);
        next_cycle();
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            sample();
            check("t5_valid", out_valid, 1);
            check("t5_pc",    out_pc,    (8'hFE + k) & 8'hFF);
            next_cycle();
        end

        // Reset pulse mid-stream
        do_reset();
        for (int k = 0; k < 4; k++) next_cycle();
        sample();                   // c4
        check("t6_pre_valid", out_valid, 1);
        check("t6_pre_pc",    out_pc,    2);
        next_cycle();
        rst = 1'b1;                 // c5
        sample();
        check("t6_rst_req", imem_req, 0);
        next_cycle();
        rst = 1'b0;
        sample();                   // c6
        check("t6_valid0", out_valid, 0);
        check("t6_req",    imem_req,  1);
        check("t6_addr",   imem_addr, 0);
        next_cycle();
        sample();                   // c7
        check("t6_valid1", out_valid, 0);
        check("t6_addr1",  imem_addr, 1);
        next_cycle();
        sample();                   // c8
        check("t6_valid2", out_valid, 1);
        check("t6_pc",     out_pc,    0);
        check("t6_ins",    out_ins,   16'h1200);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
